ts_packet_monitor: RTL and testbench
====================================

// Module: ts_packet_monitor
// PURPOSE
//  Consumes the 9-bit {sync,byte} MPEG2-TS stream from the output FIFO read side.
//  Acquires and tracks 188-byte packet alignment with a sync lock FSM.
//  Parses each packet header (TEI, PUSI, PID, AFC, CC) and checks the continuity counter of one selected PID.
//  Re-emits aligned bytes with SOP/EOP markers and keeps saturating QoS counters.
// PARAMETERS
//  PKT_LEN        188    bytes per TS packet
//  SYNC_BYTE      8'h47  expected first byte of every packet
//  LOCK_THRESH    3      consecutive good sync boundaries needed to reach LOCK
//  UNLOCK_THRESH  3      consecutive bad boundaries in LOCK that force HUNT
//  CNT_WIDTH      16     width of pkt_count / err_count
// PORTS
//  clk          in   1          stream clock (FIFO read clock)
//  rstn         in   1          async active-low reset
//  data_in      in   9          [8]=sync flag, [7:0]=TS byte
//  valid_in     in   1          data_in valid this cycle
//  pid_sel      in   13         PID whose continuity is checked
//  data_out     out  8          aligned TS byte
//  valid_out    out  1          data_out valid (LOCK only)
//  sop_out      out  1          data_out is byte 0 of a packet
//  eop_out      out  1          data_out is byte PKT_LEN-1
//  lock         out  1          1 while FSM is in LOCK
//  hdr_valid    out  1          1-cycle pulse: pid_out/cc_out/tei_out/pusi_out updated
//  pid_out      out  13         PID of current packet
//  cc_out       out  4          continuity counter of current packet
//  tei_out      out  1          transport error indicator
//  pusi_out     out  1          payload unit start indicator
//  cc_err       out  1          1-cycle pulse: CC discontinuity on pid_sel
//  sync_loss    out  1          1-cycle pulse: LOCK -> HUNT
//  pkt_count    out  CNT_WIDTH  packets completed in LOCK, saturating
//  err_count    out  CNT_WIDTH  cc_err + bad boundaries in LOCK, saturating
// BEHAVIOUR
//  Reset: one clock; reset is asynchronous and active-low. All outputs 0; FSM=HUNT; pos=0; cc_seen=0.
//  valid_in=0: no state change; pos, FSM and counters hold; valid_out=0.
//  "Good byte": valid_in & data_in[8] & data_in[7:0]==SYNC_BYTE. Sync flag with another value = bad.
//  pos counts accepted bytes 0..PKT_LEN-1 and wraps to 0; pos=0 is the boundary.
//  Boundary check applies only to bytes accepted at pos=0; the sync flag elsewhere is ignored.
//  FSM:
//   HUNT:   good byte -> VERIFY, pos=1, good_cnt=1; otherwise stay.
//   VERIFY: at pos=0, good -> good_cnt++; if good_cnt+1==LOCK_THRESH -> LOCK (this byte is output as SOP).
//           Bad -> HUNT.
//   LOCK:   at pos=0, good -> miss_cnt=0; bad -> miss_cnt++, err_count++.
//           If miss_cnt+1==UNLOCK_THRESH -> HUNT and pulse sync_loss.
//           Bad bytes below the threshold stay in the stream, position-aligned.
//  Datapath: 1-cycle latency. Byte accepted at cycle t in LOCK (incl. the entering byte) -> data_out/valid_out at t+1.
//   sop_out=(pos==0); eop_out=(pos==PKT_LEN-1).
//  Header decode (LOCK only):
//   byte1: TEI=[7], PUSI=[6], PID[12:8]=[4:0]
//   byte2: PID[7:0]
//   byte3: AFC=[5:4], CC=[3:0]
//   hdr_valid pulses in the same cycle data_out carries byte 3.
//  CC check: only when PID==pid_sel and PID!=13'h1FFF.
//   If cc_seen=0: store CC, set cc_seen, no error.
//   Otherwise expected = last+1 mod 16 when AFC[0]=1 (payload), else expected = last.
//   Mismatch pulses cc_err with hdr_valid and increments err_count. Last is always updated to the received CC.
//   cc_seen clears on entering HUNT or on any pid_sel change.
//  pkt_count increments on eop in LOCK.
//  Both counters saturate at all-ones. If both error sources fire in one cycle, err_count still increments by 1.
//  A packet cut by the LOCK->HUNT transition emits no eop and is not counted.
// STRUCTURE
//  ts_pkg: SYNC_BYTE, PKT_LEN, NULL_PID=13'h1FFF, state enum {HUNT,VERIFY,LOCK}, header field offsets.
//  Sub-module ts_sync_lock: FSM + pos counter + good/miss counters.
//   Outputs: lock, pos, sync_loss, bad_boundary. Header parse, CC check and counters stay in the top.
// TESTING
//  T1 Three clean packets: first byte {1,47} -> lock=1 one cycle after the 3rd sync byte;
//     sop_out with data_out=0x47; no output during packets 1-2.
//  T2 Locked; packet 4 boundary {1,0x00}, packet 5 good -> err_count=1, lock stays 1.
//     Three consecutive bad boundaries -> sync_loss pulse, lock=0, valid_out=0.
//  T3 pid_sel=0x100; CC sequence 5,6,8 with AFC=01 -> one cc_err at the 3rd header, err_count=1.
//     AFC=10 with CC repeated -> no cc_err.
//  T4 Header bytes 0x47,0x5F,0xFF,0x1A -> pid_out=0x1FFF, pusi=1, tei=0, cc_out=0xA; null PID never flags cc_err.
//  T5 Random valid_in gaps (~30% idle) over 10 packets -> identical data_out bytes; pkt_count=packets after lock.
//  T6 Assert rstn low mid-packet in LOCK -> all outputs 0 immediately; after release, re-lock needs LOCK_THRESH boundaries.

Source files
------------

// File: rtl/ts_pkg.sv
// ts_pkg: shared constants and types for the MPEG2-TS packet monitor.
//   PKT_LEN / SYNC_BYTE      packet framing
//   LOCK_THRESH / UNLOCK_THRESH  sync lock hysteresis
//   CNT_WIDTH                QoS counter width
//   NULL_PID                 stuffing PID, never CC-checked
//   HDR_B1..HDR_B3           packet offsets of the header bytes after sync
//   sync_state_e             sync lock FSM states
package ts_pkg;
    localparam int          PKT_LEN       = 188;
    localparam logic [7:0]  SYNC_BYTE     = 8'h47;
    localparam int          LOCK_THRESH   = 3;
    localparam int          UNLOCK_THRESH = 3;
    localparam int          CNT_WIDTH     = 16;
    localparam logic [12:0] NULL_PID      = 13'h1FFF;

    // Header byte offsets within a packet (byte 0 is the sync byte).
    localparam int HDR_B1 = 1;  // TEI, PUSI, PID[12:8]
    localparam int HDR_B2 = 2;  // PID[7:0]
    localparam int HDR_B3 = 3;  // AFC, CC

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCK   = 2'd2
    } sync_state_e;
endpackage

// File: rtl/ts_sync_lock.sv
// ts_sync_lock: packet alignment FSM for a {sync,byte} TS stream.
//   Tracks byte position within a packet and hunts/verifies/locks on the
//   sync byte seen at each packet boundary (pos == 0).
// Ports:
//   clk, rstn      clock, async active-low reset
//   valid_in       a byte is offered this cycle
//   data_in[8:0]   [8] sync flag, [7:0] TS byte
//   lock           FSM currently in LOCK
//   pos            position of the byte offered this cycle
//   sync_loss      comb pulse: this byte forces LOCK -> HUNT
//   bad_boundary   comb pulse: bad sync at a boundary while locked
//   emit           comb: this byte belongs to the locked output stream
module ts_sync_lock
    import ts_pkg::*;
#(
    parameter int         P_LEN    = PKT_LEN,
    parameter logic [7:0] P_SYNC   = SYNC_BYTE,
    parameter int         P_LOCK   = LOCK_THRESH,
    parameter int         P_UNLOCK = UNLOCK_THRESH,
    localparam int        POS_W    = $clog2(P_LEN)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             valid_in,
    input  logic [8:0]       data_in,
    output logic             lock,
    output logic [POS_W-1:0] pos,
    output logic             sync_loss,
    output logic             bad_boundary,
    output logic             emit
);
    localparam int GW = $clog2(P_LOCK + 1);
    localparam int MW = $clog2(P_UNLOCK + 1);

    sync_state_e      state_q, state_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [GW-1:0]    good_q, good_d;
    logic [MW-1:0]    miss_q, miss_d;

    logic             good;
    logic             at_bnd;
    logic [POS_W-1:0] pos_inc;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= HUNT;
            pos_q   <= '0;
            good_q  <= '0;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            good_q  <= good_d;
            miss_q  <= miss_d;
        end
    end

    always_comb begin
        good         = data_in[8] && (data_in[7:0] == P_SYNC);
        at_bnd       = (pos_q == '0);
        pos_inc      = (pos_q == POS_W'(P_LEN - 1)) ? '0 : pos_q + 1'b1;
        state_d      = state_q;
        pos_d        = pos_q;
        good_d       = good_q;
        miss_d       = miss_q;
        sync_loss    = 1'b0;
        bad_boundary = 1'b0;

        if (valid_in) begin
            unique case (state_q)
                HUNT: begin
                    // Every byte is a candidate boundary until one is good.
                    if (good) begin
                        state_d = VERIFY;
                        pos_d   = POS_W'(1);
                        good_d  = GW'(1);
                    end
                end
                VERIFY: begin
                    if (!at_bnd) begin
                        pos_d = pos_inc;
                    end else if (good) begin
                        pos_d  = POS_W'(1);
                        good_d = good_q + 1'b1;
                        if (int'(good_q) + 1 == P_LOCK) begin
                            state_d = LOCK;
                            miss_d  = '0;
                        end
                    end else begin
                        state_d = HUNT;
                        pos_d   = '0;
                        good_d  = '0;
                    end
                end
                LOCK: begin
                    pos_d = pos_inc;
                    if (at_bnd) begin
                        if (good) begin
                            miss_d = '0;
                        end else begin
                            // Bad boundaries below threshold keep alignment.
                            bad_boundary = 1'b1;
                            miss_d       = miss_q + 1'b1;
                            if (int'(miss_q) + 1 == P_UNLOCK) begin
                                state_d   = HUNT;
                                pos_d     = '0;
                                good_d    = '0;
                                miss_d    = '0;
                                sync_loss = 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                    pos_d   = '0;
                end
            endcase
        end
    end

    // The byte that enters LOCK is emitted; the byte that drops it is not.
    assign emit = valid_in && (state_d == LOCK);
    assign lock = (state_q == LOCK);
    assign pos  = pos_q;
endmodule

// File: rtl/ts_packet_monitor.sv
// ts_packet_monitor: aligns a {sync,byte} MPEG2-TS stream, re-emits it with
// SOP/EOP markers, decodes headers, checks CC of one PID and keeps QoS counts.
// Ports:
//   clk, rstn        clock, async active-low reset
//   data_in[8:0]     [8] sync flag, [7:0] TS byte;  valid_in qualifies it
//   pid_sel[12:0]    PID whose continuity counter is checked
//   data_out/valid_out/sop_out/eop_out   aligned stream, 1-cycle latency
//   lock             sync FSM in LOCK
//   hdr_valid        pulse with byte 3 on data_out; pid/cc/tei/pusi_out updated
//   cc_err           pulse with hdr_valid on a CC discontinuity of pid_sel
//   sync_loss        pulse when LOCK is lost
//   pkt_count        packets completed in LOCK (saturating)
//   err_count        CC errors + bad boundaries in LOCK (saturating)
module ts_packet_monitor
    import ts_pkg::*;
#(
    parameter int CNT_W = CNT_WIDTH
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [8:0]       data_in,
    input  logic             valid_in,
    input  logic [12:0]      pid_sel,
    output logic [7:0]       data_out,
    output logic             valid_out,
    output logic             sop_out,
    output logic             eop_out,
    output logic             lock,
    output logic             hdr_valid,
    output logic [12:0]      pid_out,
    output logic [3:0]       cc_out,
    output logic             tei_out,
    output logic             pusi_out,
    output logic             cc_err,
    output logic             sync_loss,
    output logic [CNT_W-1:0] pkt_count,
    output logic [CNT_W-1:0] err_count
);
    localparam int POS_W = $clog2(PKT_LEN);

    logic [POS_W-1:0] pos;
    logic             lock_w, sync_loss_w, bad_bnd, emit;

    ts_sync_lock u_sync (
        .clk          (clk),
        .rstn         (rstn),
        .valid_in     (valid_in),
        .data_in      (data_in),
        .lock         (lock_w),
        .pos          (pos),
        .sync_loss    (sync_loss_w),
        .bad_boundary (bad_bnd),
        .emit         (emit)
    );

    logic [7:0]       data_out_q, data_out_d;
    logic             valid_out_q, valid_out_d, sop_q, sop_d, eop_q, eop_d;
    logic             hdr_valid_q, hdr_valid_d;
    logic [12:0]      pid_out_q, pid_out_d;
    logic [3:0]       cc_out_q, cc_out_d;
    logic             tei_q, tei_d, pusi_q, pusi_d;
    logic             cc_err_q, cc_err_d, sync_loss_q, sync_loss_d;
    logic [CNT_W-1:0] pkt_count_q, pkt_count_d, err_count_q, err_count_d;
    // Header fields collected from bytes 1..2 before publishing at byte 3.
    logic             tei_cap_q, tei_cap_d, pusi_cap_q, pusi_cap_d;
    logic [4:0]       pid_hi_q, pid_hi_d;
    logic [7:0]       pid_lo_q, pid_lo_d;
    logic             cc_seen_q, cc_seen_d;
    logic [3:0]       cc_last_q, cc_last_d;
    logic [12:0]      pid_sel_q;

    logic [7:0]  byte_in;
    logic [12:0] cur_pid;
    logic [3:0]  cc_exp;
    logic        seen_eff, hdr_now;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
            sop_q       <= 1'b0;
            eop_q       <= 1'b0;
            hdr_valid_q <= 1'b0;
            pid_out_q   <= '0;
            cc_out_q    <= '0;
            tei_q       <= 1'b0;
            pusi_q      <= 1'b0;
            cc_err_q    <= 1'b0;
            sync_loss_q <= 1'b0;
            pkt_count_q <= '0;
            err_count_q <= '0;
            tei_cap_q   <= 1'b0;
            pusi_cap_q  <= 1'b0;
            pid_hi_q    <= '0;
            pid_lo_q    <= '0;
            cc_seen_q   <= 1'b0;
            cc_last_q   <= '0;
            pid_sel_q   <= '0;
        end else begin
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            sop_q       <= sop_d;
            eop_q       <= eop_d;
            hdr_valid_q <= hdr_valid_d;
            pid_out_q   <= pid_out_d;
            cc_out_q    <= cc_out_d;
            tei_q       <= tei_d;
            pusi_q      <= pusi_d;
            cc_err_q    <= cc_err_d;
            sync_loss_q <= sync_loss_d;
            pkt_count_q <= pkt_count_d;
            err_count_q <= err_count_d;
            tei_cap_q   <= tei_cap_d;
            pusi_cap_q  <= pusi_cap_d;
            pid_hi_q    <= pid_hi_d;
            pid_lo_q    <= pid_lo_d;
            cc_seen_q   <= cc_seen_d;
            cc_last_q   <= cc_last_d;
            pid_sel_q   <= pid_sel;
        end
    end

    always_comb begin
        byte_in     = data_in[7:0];
        cur_pid     = {pid_hi_q, pid_lo_q};
        hdr_now     = emit && (pos == POS_W'(HDR_B3));
        // CC history is only meaningful for the current pid_sel while locked.
        seen_eff    = cc_seen_q && lock_w && (pid_sel == pid_sel_q);
        cc_exp      = byte_in[4] ? cc_last_q + 4'd1 : cc_last_q;

        data_out_d  = emit ? byte_in : data_out_q;
        valid_out_d = emit;
        sop_d       = emit && (pos == '0);
        eop_d       = emit && (pos == POS_W'(PKT_LEN - 1));
        hdr_valid_d = hdr_now;
        pid_out_d   = pid_out_q;
        cc_out_d    = cc_out_q;
        tei_d       = tei_q;
        pusi_d      = pusi_q;
        cc_err_d    = 1'b0;
        sync_loss_d = sync_loss_w;
        tei_cap_d   = tei_cap_q;
        pusi_cap_d  = pusi_cap_q;
        pid_hi_d    = pid_hi_q;
        pid_lo_d    = pid_lo_q;
        cc_seen_d   = seen_eff;
        cc_last_d   = cc_last_q;
        pkt_count_d = pkt_count_q;
        err_count_d = err_count_q;

        if (emit && pos == POS_W'(HDR_B1)) begin
            tei_cap_d  = byte_in[7];
            pusi_cap_d = byte_in[6];
            pid_hi_d   = byte_in[4:0];
        end
        if (emit && pos == POS_W'(HDR_B2)) begin
            pid_lo_d = byte_in;
        end
        if (hdr_now) begin
            pid_out_d = cur_pid;
            cc_out_d  = byte_in[3:0];
            tei_d     = tei_cap_q;
            pusi_d    = pusi_cap_q;
            if (cur_pid == pid_sel && cur_pid != NULL_PID) begin
                cc_err_d  = seen_eff && (byte_in[3:0] != cc_exp);
                cc_seen_d = 1'b1;
                cc_last_d = byte_in[3:0];
            end
        end

        if (eop_d && pkt_count_q != '1) pkt_count_d = pkt_count_q + 1'b1;
        // Both error sources together still count once.
        if ((bad_bnd || cc_err_d) && err_count_q != '1) err_count_d = err_count_q + 1'b1;
    end

    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;
    assign sop_out   = sop_q;
    assign eop_out   = eop_q;
    assign lock      = lock_w;
    assign hdr_valid = hdr_valid_q;
    assign pid_out   = pid_out_q;
    assign cc_out    = cc_out_q;
    assign tei_out   = tei_q;
    assign pusi_out  = pusi_q;
    assign cc_err    = cc_err_q;
    assign sync_loss = sync_loss_q;
    assign pkt_count = pkt_count_q;
    assign err_count = err_count_q;
endmodule

// File: tb/tb_ts_packet_monitor.sv
// tb_ts_packet_monitor: directed bench for ts_packet_monitor.
module tb_ts_packet_monitor;
    localparam int PKT = 188;

    logic        clk = 1'b0;
    logic        rstn;
    logic [8:0]  data_in;
    logic        valid_in;
    logic [12:0] pid_sel;
    logic [7:0]  data_out;
    logic        valid_out, sop_out, eop_out, lock, hdr_valid;
    logic [12:0] pid_out;
    logic [3:0]  cc_out;
    logic        tei_out, pusi_out, cc_err, sync_loss;
    logic [15:0] pkt_count, err_count;

    ts_packet_monitor dut (
        .clk(clk), .rstn(rstn), .data_in(data_in), .valid_in(valid_in),
        .pid_sel(pid_sel), .data_out(data_out), .valid_out(valid_out),
        .sop_out(sop_out), .eop_out(eop_out), .lock(lock),
        .hdr_valid(hdr_valid), .pid_out(pid_out), .cc_out(cc_out),
        .tei_out(tei_out), .pusi_out(pusi_out), .cc_err(cc_err),
        .sync_loss(sync_loss), .pkt_count(pkt_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // per-packet observation tallies and snapshots
    int p_valid, p_sop, p_eop, p_hdr, p_ccerr, p_sloss;
    logic       s0_lock, s0_valid, s0_sop, s0_sloss;
    logic [7:0] s0_data;
    logic       h_valid, h_tei, h_pusi, h_ccerr;
    logic [12:0] h_pid;
    logic [3:0]  h_cc;
    logic [7:0]  h_data;
    logic [7:0] outq[$];
    logic [7:0] expq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] pkt_byte(input int i, input logic [7:0] sb,
        input logic [12:0] pid, input logic [1:0] afc, input logic [3:0] cc,
        input logic tei, input logic pusi, input int seed);
        logic [8:0] b;
        case (i)
            0:       b = {1'b1, sb};
            1:       b = {1'b0, tei, pusi, 1'b0, pid[12:8]};
            2:       b = {1'b0, pid[7:0]};
            3:       b = {1'b0, 2'b00, afc, cc};
            default: b = {1'b0, 8'((seed * 7 + i * 13) & 255)};
        endcase
        return b;
    endfunction

    task automatic cyc(input logic v, input logic [8:0] d);
        valid_in = v;
        data_in  = d;
        @(posedge clk);
        #1;
        if (valid_out) begin
            outq.push_back(data_out);
            p_valid++;
            if (sop_out) p_sop++;
            if (eop_out) p_eop++;
        end
        if (hdr_valid) p_hdr++;
        if (cc_err)    p_ccerr++;
        if (sync_loss) p_sloss++;
    endtask

    task automatic send_pkt(input logic [7:0] sb, input logic [12:0] pid,
        input logic [1:0] afc, input logic [3:0] cc, input logic tei,
        input logic pusi, input int seed, input bit gaps, input bit keep);
        logic [8:0] b;
        p_valid = 0; p_sop = 0; p_eop = 0; p_hdr = 0; p_ccerr = 0; p_sloss = 0;
        for (int i = 0; i < PKT; i++) begin
            // idle cycles carry a fake sync byte that must be ignored
            if (gaps) while ($urandom_range(0, 99) < 30) cyc(1'b0, 9'h147);
            b = pkt_byte(i, sb, pid, afc, cc, tei, pusi, seed);
            if (keep) expq.push_back(b[7:0]);
            cyc(1'b1, b);
            if (i == 0) begin
                s0_lock = lock; s0_valid = valid_out; s0_sop = sop_out;
                s0_data = data_out; s0_sloss = sync_loss;
            end
            if (i == 3) begin
                h_valid = hdr_valid; h_pid = pid_out; h_cc = cc_out;
                h_tei = tei_out; h_pusi = pusi_out; h_ccerr = cc_err; h_data = data_out;
            end
        end
    endtask

    initial begin
        int nmis;
        logic [8:0] b;
        rstn = 1'b0; valid_in = 1'b0; data_in = '0; pid_sel = 13'h100;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_valid", valid_out, 0);
        chk("rst_lock",  lock, 0);
        chk("rst_data",  data_out, 0);
        chk("rst_pid",   pid_out, 0);
        chk("rst_cnts",  {pkt_count, err_count}, 0);
        rstn = 1'b1;
        cyc(1'b0, 9'h147);
        chk("idle_lock", lock, 0);

        // T1: lock on the third good boundary
        send_pkt(8'h47, 13'h100, 2'b01, 4'd3, 0, 0, 1, 0, 0);
        chk("t1_p1_out", p_valid, 0);
        send_pkt(8'h47, 13'h100, 2'b01, 4'd4, 0, 0, 2, 0, 0);
        chk("t1_p2_out", p_valid, 0);
        chk("t1_p2_lock", lock, 0);
        send_pkt(8'h47, 13'h100, 2'b01, 4'd5, 0, 0, 3, 0, 0);
        chk("t1_s0_lock", s0_lock, 1);
        chk("t1_s0_sop",  {s0_valid, s0_sop}, 2'b11);
        chk("t1_s0_data", s0_data, 8'h47);
        chk("t1_p3_nval", p_valid, PKT);
        chk("t1_p3_sopeop", {p_sop[3:0], p_eop[3:0]}, 8'h11);
        chk("t1_hdr", {h_valid, h_pid, h_cc, h_data}, {1'b1, 13'h100, 4'd5, 8'h15});
        chk("t1_pktcnt", pkt_count, 1);

        // T3: CC 5,6,8 -> one error; AFC=10 repeat is fine
        send_pkt(8'h47, 13'h100, 2'b01, 4'd6, 0, 0, 4, 0, 0);
        chk("t3_cc6", p_ccerr, 0);
        send_pkt(8'h47, 13'h100, 2'b01, 4'd8, 0, 0, 5, 0, 0);
        chk("t3_cc8_err", {h_valid, h_ccerr}, 2'b11);
        chk("t3_cc8_n", p_ccerr, 1);
        chk("t3_errcnt", err_count, 1);
        send_pkt(8'h47, 13'h100, 2'b10, 4'd8, 0, 0, 6, 0, 0);
        chk("t3_afc10", p_ccerr, 0);
        send_pkt(8'h47, 13'h100, 2'b01, 4'd9, 0, 0, 7, 0, 0);
        chk("t3_cc9", p_ccerr, 0);

        // T4: null PID header decode; never CC-checked
        pid_sel = 13'h1FFF;
        send_pkt(8'h47, 13'h1FFF, 2'b01, 4'hA, 0, 1, 8, 0, 0);
        chk("t4_hdr", {h_pid, h_pusi, h_tei, h_cc}, {13'h1FFF, 1'b1, 1'b0, 4'hA});
        chk("t4_b3", h_data, 8'h1A);
        send_pkt(8'h47, 13'h1FFF, 2'b01, 4'hA, 0, 1, 9, 0, 0);
        send_pkt(8'h47, 13'h1FFF, 2'b01, 4'hA, 0, 1, 10, 0, 0);
        chk("t4_nullcc", p_ccerr, 0);
        chk("t4_errcnt", err_count, 1);
        chk("t4_pktcnt", pkt_count, 8);
        pid_sel = 13'h100;

        // T2: one bad boundary tolerated, three in a row lose lock
        send_pkt(8'h00, 13'h100, 2'b01, 4'd0, 0, 0, 11, 0, 0);
        chk("t2_bad_kept", {s0_lock, s0_valid, s0_sop, s0_data}, {3'b111, 8'h00});
        chk("t2_err1", err_count, 2);
        send_pkt(8'h47, 13'h100, 2'b01, 4'd1, 0, 0, 12, 0, 0);
        chk("t2_good_lock", lock, 1);
        send_pkt(8'h00, 13'h100, 2'b01, 4'd2, 0, 0, 13, 0, 0);
        send_pkt(8'h12, 13'h100, 2'b01, 4'd3, 0, 0, 14, 0, 0);
        chk("t2_err3", err_count, 4);
        chk("t2_still_lock", lock, 1);
        send_pkt(8'h00, 13'h100, 2'b01, 4'd4, 0, 0, 15, 0, 0);
        chk("t2_loss", {s0_sloss, s0_lock, s0_valid}, 3'b100);
        chk("t2_loss_n", p_sloss, 1);
        chk("t2_cut_out", p_valid, 0);
        chk("t2_err5", err_count, 5);
        chk("t2_pktcnt", pkt_count, 12);

        // T5: random idle gaps; output stream equals packets 3..10
        outq.delete(); expq.delete();
        for (int k = 0; k < 10; k++)
            send_pkt(8'h47, 13'h200, 2'b01, 4'(k), 0, 0, 20 + k, 1, k >= 2);
        chk("t5_len", outq.size(), 8 * PKT);
        nmis = 0;
        for (int i = 0; i < expq.size() && i < outq.size(); i++)
            if (outq[i] !== expq[i]) nmis++;
        chk("t5_bytes", nmis, 0);
        chk("t5_pktcnt", pkt_count, 20);
        chk("t5_errcnt", err_count, 5);

        // T6: async reset mid-packet while locked
        for (int i = 0; i < 100; i++) begin
            b = pkt_byte(i, 8'h47, 13'h200, 2'b01, 4'd10, 0, 0, 30);
            cyc(1'b1, b);
        end
        chk("t6_pre_lock", lock, 1);
        #3 rstn = 1'b0;
        #1;
        chk("t6_rst_out", {lock, valid_out, sop_out, hdr_valid}, 0);
        chk("t6_rst_cnt", {pkt_count, err_count}, 0);
        chk("t6_rst_hdr", {pid_out, cc_out}, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        send_pkt(8'h47, 13'h300, 2'b01, 4'd0, 0, 0, 40, 0, 0);
        send_pkt(8'h47, 13'h300, 2'b01, 4'd1, 0, 0, 41, 0, 0);
        chk("t6_relock_wait", {lock, 8'(p_valid)}, 0);
        send_pkt(8'h47, 13'h300, 2'b01, 4'd2, 0, 0, 42, 0, 0);
        chk("t6_relock", {s0_lock, s0_sop}, 2'b11);
        chk("t6_pktcnt", pkt_count, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
